spi_to_nitta_assembler: RTL and testbench

Receive-path stage of the SPI slave processing unit. It sits directly downstream of the SPI driver's received-byte output. It packs SPI_DATA_WIDTH-bit bytes into DATA_WIDTH-bit words and stores them in a double-banked word store. Words received during one computational cycle are handed to the NITTA side at the next `signal_cycle`, where `signal_oe` reads them in arrival order.

---
 rtl/spi_to_nitta_assembler_pkg.sv | 28 ++
 rtl/spi_to_nitta_assembler_if.sv | 28 ++
 rtl/spi_to_nitta_assembler_word_bank.sv | 29 ++
 rtl/spi_to_nitta_assembler.sv | 115 +++++++++++
 tb/tb_spi_to_nitta_assembler.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_to_nitta_assembler_pkg.sv
// Shared definitions for the SPI receive-path word assembler.
// Holds the attribute bit positions and the derived widths:
// bytes per word, counter widths and bank address width.
package spi_to_nitta_assembler_pkg;

  localparam int ATTR_VALID    = 0;
  localparam int ATTR_OVERFLOW = 1;

  // Number of SPI bytes that form one NITTA word.
  function automatic int bytes_per_word(int data_width, int spi_data_width);
    return data_width / spi_data_width;
  endfunction

  // Word counters must hold 0..buf_size inclusive.
  function automatic int wr_cnt_width(int buf_size);
    return $clog2(buf_size + 1);
  endfunction

  // Byte counter counts 0..bytes-1; keep at least one bit.
  function automatic int byte_cnt_width(int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  function automatic int addr_width(int buf_size);
    return (buf_size > 1) ? $clog2(buf_size) : 1;
  endfunction

endpackage

// File: rtl/spi_to_nitta_assembler_if.sv
// Signal bundle between the SPI driver / NITTA side and the assembler.
//   spi_ready, from_spi, frame_end : received-byte stream from the SPI driver
//   signal_cycle, signal_oe        : NITTA cycle boundary and read strobe
//   data_out, attr_out             : current word and its attributes
// master drives the strobes, slave (the assembler) drives data_out/attr_out.
interface spi_to_nitta_assembler_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ATTR_WIDTH     = 4,
  parameter int SPI_DATA_WIDTH = 8
);
  logic                      spi_ready;
  logic [SPI_DATA_WIDTH-1:0] from_spi;
  logic                      frame_end;
  logic                      signal_cycle;
  logic                      signal_oe;
  logic [DATA_WIDTH-1:0]     data_out;
  logic [ATTR_WIDTH-1:0]     attr_out;

  modport master (
    output spi_ready, from_spi, frame_end, signal_cycle, signal_oe,
    input  data_out, attr_out
  );

  modport slave (
    input  spi_ready, from_spi, frame_end, signal_cycle, signal_oe,
    output data_out, attr_out
  );
endinterface

// File: rtl/spi_to_nitta_assembler_word_bank.sv
// spi_word_bank: BUF_SIZE x DATA_WIDTH word store.
//   clk         : clock
//   wr/waddr/wdata : synchronous write port
//   raddr/rdata : asynchronous read port (reads 0 past the end)
// Contents are deliberately not reset.
module spi_word_bank
  import spi_to_nitta_assembler_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_SIZE   = 6,
  parameter int AW         = addr_width(BUF_SIZE)
) (
  input  logic                  clk,
  input  logic                  wr,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [BUF_SIZE];

  always_ff @(posedge clk) begin
    if (wr) mem[waddr] <= wdata;
  end

  assign rdata = (int'(raddr) < BUF_SIZE) ? mem[raddr] : '0;

endmodule

// File: rtl/spi_to_nitta_assembler.sv
// spi_to_nitta_assembler: packs MSB-first SPI bytes into NITTA words and
// stores them in a double-banked store. Words gathered during one NITTA
// cycle become readable after the next signal_cycle, in arrival order.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of spi_to_nitta_assembler_if
//              (spi_ready/from_spi/frame_end in, signal_cycle/signal_oe in,
//               data_out/attr_out out; attr bit0 valid, bit1 overflow)
module spi_to_nitta_assembler
  import spi_to_nitta_assembler_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ATTR_WIDTH     = 4,
  parameter int SPI_DATA_WIDTH = 8,
  parameter int BUF_SIZE       = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  spi_to_nitta_assembler_if.slave  bus
);

  localparam int BYTES = bytes_per_word(DATA_WIDTH, SPI_DATA_WIDTH);
  localparam int WCW   = wr_cnt_width(BUF_SIZE);
  localparam int BCW   = byte_cnt_width(BYTES);
  localparam int AW    = addr_width(BUF_SIZE);

  logic                  bank_sel;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] word_next;
  logic [BCW-1:0]        byte_cnt;
  logic [WCW-1:0]        wr_cnt;
  logic [WCW-1:0]        rd_cnt;
  logic [WCW-1:0]        rd_ptr;
  logic                  ovf;
  logic                  rd_ovf;

  logic                  word_complete;
  logic                  fill_full;
  logic                  commit;
  logic                  drop;
  logic                  valid;
  logic [DATA_WIDTH-1:0] rdata [2];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [ATTR_WIDTH-1:0] attr;

  assign word_next     = (shreg << SPI_DATA_WIDTH) | DATA_WIDTH'(bus.from_spi);
  assign word_complete = bus.spi_ready && (byte_cnt == BCW'(BYTES - 1));
  assign fill_full     = (wr_cnt == WCW'(BUF_SIZE));
  assign commit        = word_complete && !fill_full;
  assign drop          = word_complete && fill_full;
  assign valid         = (rd_ptr < rd_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel <= 1'b0;
      shreg    <= '0;
      byte_cnt <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
      rd_ovf   <= 1'b0;
    end else begin
      if (bus.spi_ready) begin
        shreg    <= word_next;
        byte_cnt <= word_complete ? '0 : byte_cnt + 1'b1;
      end
      // Later assignment wins: a byte arriving with frame_end is processed
      // (and may commit a word) before the partial count is discarded.
      if (bus.frame_end) byte_cnt <= '0;

      if (bus.signal_cycle) begin
        // A word committed in the swap cycle is written to the outgoing
        // fill bank, so it is folded into the new read count/overflow.
        bank_sel <= ~bank_sel;
        rd_cnt   <= wr_cnt + WCW'(commit);
        rd_ptr   <= '0;
        rd_ovf   <= ovf | drop;
        wr_cnt   <= '0;
        ovf      <= 1'b0;
      end else begin
        if (commit) wr_cnt <= wr_cnt + 1'b1;
        if (drop) ovf <= 1'b1;
        if (bus.signal_oe && valid) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_bank
    spi_word_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_SIZE   (BUF_SIZE),
      .AW         (AW)
    ) u_bank (
      .clk   (clk),
      .wr    (commit && (bank_sel == 1'(i))),
      .waddr (wr_cnt[AW-1:0]),
      .wdata (word_next),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rdata[i])
    );
  end

  // Read bank is the one not being filled.
  assign rd_word = bank_sel ? rdata[0] : rdata[1];

  always_comb begin
    attr                = '0;
    attr[ATTR_VALID]    = valid;
    attr[ATTR_OVERFLOW] = rd_ovf;
  end

  assign bus.data_out = valid ? rd_word : '0;
  assign bus.attr_out = attr;

endmodule

// File: tb/tb_spi_to_nitta_assembler.sv
module tb_spi_to_nitta_assembler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_to_nitta_assembler_if #(
    .DATA_WIDTH     (32),
    .ATTR_WIDTH     (4),
    .SPI_DATA_WIDTH (8)
  ) bus ();

  spi_to_nitta_assembler #(
    .DATA_WIDTH     (32),
    .ATTR_WIDTH     (4),
    .SPI_DATA_WIDTH (8),
    .BUF_SIZE       (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words gathered this cycle, words handed to NITTA.
  logic [31:0] fill_q[$];
  logic [31:0] read_q[$];
  logic        fill_ovf  = 1'b0;
  logic        rd_ovf_m  = 1'b0;

  typedef struct {
    bit          sr;
    logic [7:0]  b;
    bit          fe;
    bit          sc;
    bit          oe;
    logic [31:0] exp_data;
    logic [3:0]  exp_attr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input bit sr, input logic [7:0] b, input bit fe, input bit sc, input bit oe);
    bus.spi_ready    = sr;
    bus.from_spi     = b;
    bus.frame_end    = fe;
    bus.signal_cycle = sc;
    bus.signal_oe    = oe;
    @(posedge clk);
    #1;
    bus.spi_ready    = 1'b0;
    bus.from_spi     = 8'h00;
    bus.frame_end    = 1'b0;
    bus.signal_cycle = 1'b0;
    bus.signal_oe    = 1'b0;
  endtask

  function automatic void model_commit(input logic [31:0] w);
    if (fill_q.size() < 6) fill_q.push_back(w);
    else fill_ovf = 1'b1;
  endfunction

  function automatic void model_swap();
    read_q   = fill_q;
    rd_ovf_m = fill_ovf;
    fill_q.delete();
    fill_ovf = 1'b0;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    tick(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31 - 8*i -: 8]);
    model_commit(w);
  endtask

  task automatic swap();
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    model_swap();
  endtask

  // Read out every expected word in order, then confirm the bank is empty.
  task automatic drain(input string name);
    while (read_q.size() > 0) begin
      check({name, " data"}, bus.data_out, read_q[0]);
      check({name, " attr"}, 32'(bus.attr_out), 32'({rd_ovf_m, 1'b1}));
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      void'(read_q.pop_front());
    end
    check({name, " empty data"}, bus.data_out, 32'h0);
    check({name, " empty attr"}, 32'(bus.attr_out), 32'({rd_ovf_m, 1'b0}));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0000};
    vecs[1]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0000};
    vecs[2]  = '{1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0000};
    vecs[3]  = '{1'b1, 8'h78, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0000};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h12345678, 4'b0001};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h12345678, 4'b0001};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0,        4'b0000};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0,        4'b0000};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'b0000};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0000};

    bus.spi_ready    = 1'b0;
    bus.from_spi     = 8'h00;
    bus.frame_end    = 1'b0;
    bus.signal_cycle = 1'b0;
    bus.signal_oe    = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset data", bus.data_out, 32'h0);
    check("reset attr", 32'(bus.attr_out), 32'h0);
    rst = 1'b0;

    // Single word, cycle by cycle.
    for (int i = 0; i < 11; i++) begin
      tick(vecs[i].sr, vecs[i].b, vecs[i].fe, vecs[i].sc, vecs[i].oe);
      check($sformatf("vec%0d data", i), bus.data_out, vecs[i].exp_data);
      check($sformatf("vec%0d attr", i), 32'(bus.attr_out), 32'(vecs[i].exp_attr));
    end

    // Partial word discarded by frame_end, then a clean word.
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    send_word(32'h01020304);
    swap();
    drain("partial");

    // Last byte together with frame_end still commits; next word is aligned.
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    tick(1'b1, 8'hDD, 1'b1, 1'b0, 1'b0);
    model_commit(32'hAABBCCDD);
    send_word(32'h11223344);
    swap();
    drain("byte+fe");

    // Overflow: seventh word dropped, flag sticky until the next swap.
    for (int i = 1; i <= 7; i++) send_word(32'(i));
    swap();
    drain("overflow");
    swap();
    drain("ovf cleared");

    // Fourth byte coincides with signal_cycle.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    tick(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    model_commit(32'h11223344);
    model_swap();
    drain("commit+swap");

    // Word straddling a swap lands in the new fill bank.
    send_byte(8'h9A);
    send_byte(8'hBC);
    swap();
    drain("straddle first");
    send_byte(8'hDE);
    send_byte(8'hF0);
    model_commit(32'h9ABCDEF0);
    swap();
    drain("straddle");

    // signal_oe with signal_cycle: swap wins, pointer restarts at 0.
    send_word(32'h11111111);
    swap();
    send_word(32'h22222222);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    model_swap();
    drain("oe+swap");

    // Ping-pong: bank B fills while NITTA reads bank A.
    send_word(32'hCAFEF00D);
    swap();
    check("pingpong A", bus.data_out, read_q[0]);
    tick(1'b1, 8'hDE, 1'b0, 1'b0, 1'b1);
    void'(read_q.pop_front());
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    model_commit(32'hDEADBEEF);
    check("pingpong A read", bus.data_out, 32'h0);
    swap();
    drain("pingpong B");

    // Reset mid-word clears the read side and the partial word.
    send_word(32'h5555AAAA);
    swap();
    send_byte(8'h01);
    send_byte(8'h02);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill_q.delete();
    read_q.delete();
    fill_ovf = 1'b0;
    rd_ovf_m = 1'b0;
    check("rst mid data", bus.data_out, 32'h0);
    check("rst mid attr", 32'(bus.attr_out), 32'h0);
    send_word(32'h0A0B0C0D);
    swap();
    drain("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
